// File: rtl/piece_collision_check_pkg.sv
// Shared types for the candidate-placement collision checker: board and piece
// containers, the per-row result struct and the checker FSM state encoding.
package piece_collision_check_pkg;

    localparam int BOARD_W   = 10;
    localparam int BOARD_H   = 20;
    localparam int PIECE_DIM = 4;

    // Locked board, indexed screen[x][y].
    typedef struct packed {
        logic [BOARD_W-1:0][BOARD_H-1:0] screen;
    } game_state_t;

    // Candidate piece, indexed piece[dx][dy], with a 5-bit origin that may wrap negative.
    typedef struct packed {
        logic [PIECE_DIM-1:0][PIECE_DIM-1:0] piece;
        logic [4:0]                          x;
        logic [4:0]                          y;
    } active_piece_grid_t;

    typedef struct packed {
        logic hit_block;
        logic hit_wall;
        logic hit_floor;
    } collision_result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } collision_state_t;

    function automatic logic any_hit(input collision_result_t r);
        return r.hit_block | r.hit_wall | r.hit_floor;
    endfunction

endpackage

// File: rtl/piece_collision_check_row_probe.sv
// Combinational probe of one piece-grid row (all four dx) against the board,
// walls and floor.
module piece_row_probe
    import piece_collision_check_pkg::*;
(
    input  game_state_t       board,
    input  logic [4:0]        x,
    input  logic [4:0]        y,
    input  logic [3:0]        row,
    input  logic [1:0]        dy,
    output collision_result_t result
);

    logic [4:0] col_x;
    logic [4:0] row_y;

    always_comb begin
        result = '0;
        col_x  = '0;
        row_y  = y + {3'b000, dy};
        for (int dx = 0; dx < PIECE_DIM; dx++) begin
            col_x = x + 5'(dx);
            if (row[dx]) begin
                if (col_x >= 5'(BOARD_W)) result.hit_wall  = 1'b1;
                if (row_y >= 5'(BOARD_H)) result.hit_floor = 1'b1;
                // The board is only indexed once both coordinates are known to be in range.
                if ((col_x < 5'(BOARD_W)) && (row_y < 5'(BOARD_H)) &&
                    board.screen[col_x[3:0]][row_y])
                    result.hit_block = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piece_collision_check.sv
// Snapshots a candidate piece placement and scans it against the locked board.
// Optional build macro: COLLISION_EARLY_EXIT_EN (stop scanning after the first hit).
//
// state | meaning
// IDLE  | ready for a request; snapshot taken on acceptance
// SCAN  | evaluating ROWS_PER_CYCLE piece rows per cycle, accumulating flags
// RESP  | result held on resp_* until resp_ready
module piece_collision_check
    import piece_collision_check_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  game_state_t        req_board,
    input  active_piece_grid_t req_piece,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_collide,
    output logic               resp_hit_block,
    output logic               resp_hit_wall,
    output logic               resp_hit_floor
);

    localparam logic [1:0] DY_STEP = 2'(ROWS_PER_CYCLE);
    localparam logic [1:0] LAST_DY = 2'(PIECE_DIM - ROWS_PER_CYCLE);

    collision_state_t   state_q, state_d;
    game_state_t        board_q;
    active_piece_grid_t piece_q;
    logic [1:0]         dy_q;
    collision_result_t  acc_q;
    collision_result_t  scan_hit;
    collision_result_t  acc_next;
    collision_result_t  grp_hit [ROWS_PER_CYCLE];

    for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_probe
        logic [1:0]        row_dy;
        logic [3:0]        row_bits;
        collision_result_t row_hit;

        assign row_dy = dy_q + 2'(g);

        always_comb begin
            row_bits = '0;
            for (int dx = 0; dx < PIECE_DIM; dx++)
                row_bits[dx] = piece_q.piece[dx][row_dy];
        end

        piece_row_probe u_probe (
            .board  (board_q),
            .x      (piece_q.x),
            .y      (piece_q.y),
            .row    (row_bits),
            .dy     (row_dy),
            .result (row_hit)
        );

        assign grp_hit[g] = row_hit;
    end

    always_comb begin
        scan_hit = '0;
        for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
            scan_hit.hit_block = scan_hit.hit_block | grp_hit[g].hit_block;
            scan_hit.hit_wall  = scan_hit.hit_wall  | grp_hit[g].hit_wall;
            scan_hit.hit_floor = scan_hit.hit_floor | grp_hit[g].hit_floor;
        end
        acc_next.hit_block = acc_q.hit_block | scan_hit.hit_block;
        acc_next.hit_wall  = acc_q.hit_wall  | scan_hit.hit_wall;
        acc_next.hit_floor = acc_q.hit_floor | scan_hit.hit_floor;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = SCAN;
            SCAN: begin
                if (dy_q == LAST_DY) state_d = RESP;
`ifdef COLLISION_EARLY_EXIT_EN
                if (any_hit(acc_next)) state_d = RESP;
`endif
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            board_q <= '0;
            piece_q <= '0;
            dy_q    <= '0;
            acc_q   <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                board_q <= req_board;
                piece_q <= req_piece;
                dy_q    <= '0;
                acc_q   <= '0;
            end else if (state_q == SCAN) begin
                acc_q <= acc_next;
                dy_q  <= dy_q + DY_STEP;
            end
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_hit_block = acc_q.hit_block;
    assign resp_hit_wall  = acc_q.hit_wall;
    assign resp_hit_floor = acc_q.hit_floor;
    assign resp_collide   = any_hit(acc_q);

endmodule

// File: tb/tb_piece_collision_check.sv
// Directed self-checking bench for piece_collision_check (ROWS_PER_CYCLE=1),
// expectations adjusted when COLLISION_EARLY_EXIT_EN is defined.
module tb_piece_collision_check;
    import piece_collision_check_pkg::*;

`ifdef COLLISION_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               req_valid;
    logic               req_ready;
    game_state_t        req_board;
    active_piece_grid_t req_piece;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_collide;
    logic               resp_hit_block;
    logic               resp_hit_wall;
    logic               resp_hit_floor;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piece_collision_check #(.ROWS_PER_CYCLE(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_board      (req_board),
        .req_piece      (req_piece),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_collide   (resp_collide),
        .resp_hit_block (resp_hit_block),
        .resp_hit_wall  (resp_hit_wall),
        .resp_hit_floor (resp_hit_floor)
    );

    function automatic logic [3:0] flags();
        return {resp_collide, resp_hit_block, resp_hit_wall, resp_hit_floor};
    endfunction

    // Called at #1 after a rising edge while IDLE; returns at #1 after the accept edge.
    task automatic send(input game_state_t b, input active_piece_grid_t p);
        req_board = b;
        req_piece = p;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_req(input game_state_t b, input active_piece_grid_t p, output int lat);
        send(b, p);
        wait_resp(lat);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_board = '0; req_piece = '0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: ready=%b valid=%b flags=%b required ready=1 valid=0 flags=0000",
                     req_ready, resp_valid, flags());
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_empty();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int lat;
        p.piece[1][0] = 1'b1; p.piece[2][0] = 1'b1;
        p.piece[1][1] = 1'b1; p.piece[2][1] = 1'b1;
        p.x = 5'd4; p.y = 5'd0;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL empty_latency: got %0d required 4", lat); end
        n_tests++;
        if (flags() !== 4'b0000) begin n_fail++; $display("FAIL empty_flags: got %b required 0000", flags()); end
        release_resp();
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_release: valid=%b ready=%b required valid=0 ready=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_block();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int lat;
        b.screen[5][2] = 1'b1;
        p.piece[1][2] = 1'b1;
        p.x = 5'd4; p.y = 5'd0;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== (EE ? 3 : 4)) begin n_fail++; $display("FAIL block_latency: got %0d required %0d", lat, EE ? 3 : 4); end
        n_tests++;
        if (flags() !== 4'b1100) begin n_fail++; $display("FAIL block_flags: got %b required 1100", flags()); end
        release_resp();
    endtask

    task automatic test_wall();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int lat;
        for (int dx = 0; dx < 4; dx++) p.piece[dx][0] = 1'b1;
        p.x = 5'd8; p.y = 5'd3;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== (EE ? 1 : 4) || flags() !== 4'b1010) begin
            n_fail++;
            $display("FAIL wall_x8: lat=%0d flags=%b required lat=%0d flags=1010", lat, flags(), EE ? 1 : 4);
        end
        release_resp();
        p.x = 5'd31;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== (EE ? 1 : 4) || flags() !== 4'b1010) begin
            n_fail++;
            $display("FAIL wall_x31: lat=%0d flags=%b required lat=%0d flags=1010", lat, flags(), EE ? 1 : 4);
        end
        release_resp();
    endtask

    task automatic test_floor();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int lat;
        for (int dy = 0; dy < 4; dy++) p.piece[0][dy] = 1'b1;
        p.x = 5'd0; p.y = 5'd17;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== 4 || flags() !== 4'b1001) begin
            n_fail++;
            $display("FAIL floor_y17: lat=%0d flags=%b required lat=4 flags=1001", lat, flags());
        end
        release_resp();
        p.y = 5'd16;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== 4 || flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL floor_y16: lat=%0d flags=%b required lat=4 flags=0000", lat, flags());
        end
        release_resp();
    endtask

    task automatic test_stall();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        active_piece_grid_t pw = '0;
        int lat;
        int bad = 0;
        b.screen[5][2] = 1'b1;
        p.piece[1][2] = 1'b1;
        p.x = 5'd4; p.y = 5'd0;
        for (int dx = 0; dx < 4; dx++) pw.piece[dx][0] = 1'b1;
        pw.x = 5'd8;
        run_req(b, p, lat);
        req_piece = pw;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || flags() !== 4'b1100 || req_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles, last valid=%b flags=%b ready=%b required 0",
                     bad, resp_valid, flags(), req_ready);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b ready=%b required valid=0 ready=1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_accept: ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_midscan_board();
        game_state_t b0 = '0;
        game_state_t b1 = '0;
        active_piece_grid_t p = '0;
        int lat;
        b1.screen[5][8] = 1'b1;
        p.piece[2][3] = 1'b1;
        p.x = 5'd3; p.y = 5'd5;
        send(b0, p);
        req_board = b1;
        wait_resp(lat);
        n_tests++;
        if (lat !== 4 || flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL midscan_board: lat=%0d flags=%b required lat=4 flags=0000", lat, flags());
        end
        release_resp();
        run_req(b1, p, lat);
        n_tests++;
        if (lat !== 4 || flags() !== 4'b1100) begin
            n_fail++;
            $display("FAIL board_row3_hit: lat=%0d flags=%b required lat=4 flags=1100", lat, flags());
        end
        release_resp();
        req_board = '0;
    endtask

    task automatic test_reset_scan();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int seen = 0;
        int lat;
        b.screen[4][0] = 1'b1;
        p.piece[0][1] = 1'b1;
        p.x = 5'd4; p.y = 5'd31;
        send(b, p);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_scan: valid=%b ready=%b flags=%b required 0 1 0000",
                     resp_valid, req_ready, flags());
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL reset_discard: got %0d resp cycles required 0", seen); end
        run_req(b, p, lat);
        n_tests++;
        if (lat !== (EE ? 2 : 4) || flags() !== 4'b1100) begin
            n_fail++;
            $display("FAIL after_reset: lat=%0d flags=%b required lat=%0d flags=1100", lat, flags(), EE ? 2 : 4);
        end
        release_resp();
    endtask

    task automatic test_early_exit();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int lat;
        b.screen[4][0] = 1'b1;
        p.piece[0][0] = 1'b1;
        p.piece[0][3] = 1'b1;
        p.x = 5'd4; p.y = 5'd17;
        b.screen[4][17] = 1'b1;
        run_req(b, p, lat);
        n_tests++;
        if (lat !== (EE ? 1 : 4)) begin n_fail++; $display("FAIL early_exit_latency: got %0d required %0d", lat, EE ? 1 : 4); end
        n_tests++;
        if (flags() !== (EE ? 4'b1100 : 4'b1101)) begin
            n_fail++;
            $display("FAIL early_exit_flags: got %b required %b", flags(), EE ? 4'b1100 : 4'b1101);
        end
        release_resp();
    endtask

    task automatic test_back_to_back();
        game_state_t b = '0;
        active_piece_grid_t p = '0;
        int t1 = -1;
        int t2 = -1;
        p.piece[1][1] = 1'b1;
        p.x = 5'd2; p.y = 5'd2;
        req_board = b;
        req_piece = p;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
        end
        n_tests++;
        if (t1 != 5 || t2 - t1 != 6) begin
            n_fail++;
            $display("FAIL back_to_back: first=%0d gap=%0d required first=5 gap=6", t1, t2 - t1);
        end
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 resp_ready = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_drain: ready=%b valid=%b required ready=1 valid=0", req_ready, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_block();
        test_wall();
        test_floor();
        test_stall();
        test_midscan_board();
        test_reset_scan();
        test_early_exit();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
